// File: rtl/execute.sv
// Y86-64 execute stage: 64-bit ALU, condition codes, jXX/cmovXX condition evaluation,
// and the E->M pipeline register. e_valE/e_dstE/e_Cnd are combinational for forwarding.
module execute #(
  parameter int unsigned WIDTH = 64,
  parameter logic [3:0]  RNONE = 4'hF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       E_stat,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_ifun,
  input  logic [WIDTH-1:0] E_valC,
  input  logic [WIDTH-1:0] E_valA,
  input  logic [WIDTH-1:0] E_valB,
  input  logic [3:0]       E_dstE,
  input  logic [3:0]       E_dstM,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic [WIDTH-1:0] e_valE,
  output logic [3:0]       e_dstE,
  output logic             e_Cnd,
  output logic [2:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic             M_Cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM
);

  localparam logic [3:0] IHalt   = 4'd0;
  localparam logic [3:0] INop    = 4'd1;
  localparam logic [3:0] IRrmovq = 4'd2;
  localparam logic [3:0] IIrmovq = 4'd3;
  localparam logic [3:0] IRmmovq = 4'd4;
  localparam logic [3:0] IMrmovq = 4'd5;
  localparam logic [3:0] IOpq    = 4'd6;
  localparam logic [3:0] ICall   = 4'd8;
  localparam logic [3:0] IRet    = 4'd9;
  localparam logic [3:0] IPushq  = 4'd10;
  localparam logic [3:0] IPopq   = 4'd11;

  localparam logic [2:0] SAok = 3'd1;
  localparam logic [2:0] SHlt = 3'd2;
  localparam logic [2:0] SAdr = 3'd3;
  localparam logic [2:0] SIns = 3'd4;

  localparam logic [WIDTH-1:0] PosEight = {{(WIDTH-4){1'b0}}, 4'b1000};
  localparam logic [WIDTH-1:0] NegEight = {{(WIDTH-4){1'b1}}, 4'b1000};

  typedef enum logic [1:0] {AluAdd, AluSub, AluAnd, AluXor} alu_fun_e;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  alu_fun_e         alu_fun;
  logic             new_zf;
  logic             new_sf;
  logic             new_of;
  logic             zf_q;
  logic             sf_q;
  logic             of_q;
  logic             exc_m;
  logic             exc_w;
  logic             bubble;
  logic             set_cc;

  function automatic logic is_exc(input logic [2:0] s);
    return (s == SHlt) || (s == SAdr) || (s == SIns);
  endfunction

  always_comb begin
    alu_a = '0;
    case (E_icode)
      IRrmovq, IOpq:            alu_a = E_valA;
      IIrmovq, IRmmovq, IMrmovq: alu_a = E_valC;
      ICall, IPushq:            alu_a = NegEight;
      IRet, IPopq:              alu_a = PosEight;
      default:                  alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (E_icode)
      IRmmovq, IMrmovq, IOpq, ICall, IRet, IPushq, IPopq: alu_b = E_valB;
      default:                                            alu_b = '0;
    endcase
  end

  always_comb begin
    alu_fun = AluAdd;
    if (E_icode == IOpq) begin
      case (E_ifun)
        4'd1:    alu_fun = AluSub;
        4'd2:    alu_fun = AluAnd;
        4'd3:    alu_fun = AluXor;
        default: alu_fun = AluAdd;
      endcase
    end
  end

  // Subtraction is valB - valA, matching the Y86 subq operand order.
  always_comb begin
    e_valE = '0;
    new_of = 1'b0;
    unique case (alu_fun)
      AluAdd: begin
        e_valE = alu_b + alu_a;
        new_of = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (e_valE[WIDTH-1] != alu_a[WIDTH-1]);
      end
      AluSub: begin
        e_valE = alu_b - alu_a;
        new_of = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (e_valE[WIDTH-1] != alu_b[WIDTH-1]);
      end
      AluAnd: e_valE = alu_b & alu_a;
      AluXor: e_valE = alu_b ^ alu_a;
    endcase
    new_zf = (e_valE == '0);
    new_sf = e_valE[WIDTH-1];
  end

  always_comb begin
    e_Cnd = 1'b0;
    case (E_ifun)
      4'd0:    e_Cnd = 1'b1;
      4'd1:    e_Cnd = (sf_q ^ of_q) | zf_q;
      4'd2:    e_Cnd = sf_q ^ of_q;
      4'd3:    e_Cnd = zf_q;
      4'd4:    e_Cnd = !zf_q;
      4'd5:    e_Cnd = !(sf_q ^ of_q);
      4'd6:    e_Cnd = !(sf_q ^ of_q) && !zf_q;
      default: e_Cnd = 1'b0;
    endcase
  end

  // A conditional move that fails keeps its result from being written anywhere.
  assign e_dstE = ((E_icode == IRrmovq) && !e_Cnd) ? RNONE : E_dstE;

  assign exc_m  = is_exc(m_stat);
  assign exc_w  = is_exc(W_stat);
  assign bubble = exc_m || exc_w;
  assign set_cc = (E_icode == IOpq) && !bubble;

  always_ff @(posedge clk) begin
    if (reset) begin
      zf_q    <= 1'b1;
      sf_q    <= 1'b0;
      of_q    <= 1'b0;
      M_stat  <= SAok;
      M_icode <= INop;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else begin
      if (set_cc) begin
        zf_q <= new_zf;
        sf_q <= new_sf;
        of_q <= new_of;
      end
      if (bubble) begin
        M_stat  <= SAok;
        M_icode <= INop;
        M_Cnd   <= 1'b0;
        M_valE  <= '0;
        M_valA  <= '0;
        M_dstE  <= RNONE;
        M_dstM  <= RNONE;
      end else begin
        M_stat  <= E_stat;
        M_icode <= E_icode;
        M_Cnd   <= e_Cnd;
        M_valE  <= e_valE;
        M_valA  <= E_valA;
        M_dstE  <= e_dstE;
        M_dstM  <= E_dstM;
      end
    end
  end

  logic unused_halt;
  assign unused_halt = (IHalt == 4'd0);

endmodule
